// File: rtl/tinyalu_resp.sv
// TinyALU responder: captures A/B/op on start, runs add/and/xor with a
// one-cycle latency or multiply with a MUL_LAT-cycle latency, then returns a
// registered result with a single-cycle done pulse. HOLD blocks a second
// operation until start has been seen low, so each start assertion yields
// exactly one operation.
module tinyalu_resp #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [2:0]  op_q;
    logic        clear;
    logic        capture;
    logic        finish;
    logic [8:0]  sum;
    logic [15:0] alu_out;

    // rst_op behaves exactly like reset, whatever state we are in
    assign clear = start && (op == OP_RST);

    // State, counter, captured operands and the registered outputs
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            done   <= 1'b0;
            result <= 16'h0000;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            op_q   <= OP_NOP;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= finish;
            if (finish) begin
                result <= alu_out;
            end
            if (capture) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op;
            end
        end
    end

    // Next-state decision; HOLD waits for start to be seen low
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && (op != OP_NOP) && (op != OP_RST)) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = start ? HOLD : IDLE;
            end
            HOLD: begin
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture/finish strobes and the latency down-counter
    always_comb begin
        capture = (state == IDLE) && start && (op != OP_NOP) && (op != OP_RST);
        finish  = (state == EXEC) && (cnt == 4'd0);
        cnt_nxt = cnt;
        if (capture) begin
            cnt_nxt = (op == OP_MUL) ? MUL_CNT : 4'd0;
        end else if ((state == EXEC) && (cnt != 4'd0)) begin
            cnt_nxt = cnt - 4'd1;
        end
    end

    // Arithmetic on the captured operands; unused opcodes complete with zero
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        alu_out = 16'h0000;
        case (op_q)
            OP_ADD:  alu_out = {7'b0, sum};
            OP_AND:  alu_out = {8'b0, a_q & b_q};
            OP_XOR:  alu_out = {8'b0, a_q ^ b_q};
            OP_MUL:  alu_out = a_q * b_q;
            default: alu_out = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_tinyalu_resp.sv
// Bench for tinyalu_resp: two instances share one stimulus stream, one with
// the default multiply latency of 3 and one with latency 1. A behavioural
// model supplies the expected result and latency for every operation.
module tb_tinyalu_resp;

    logic        clk;
    logic        reset;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
    logic        done1;
    logic [15:0] result1;

    int n_total;
    int n_pass;
    int n_fail;
    logic [15:0] last_res;

    tinyalu_resp #(.MUL_LAT(3)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
        .done(done), .result(result)
    );

    tinyalu_resp #(.MUL_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
        .done(done1), .result(result1)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected result straight from the arithmetic rules
    function automatic logic [15:0] model_result(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [2:0] o);
        case (o)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // Edges from capture to done
    function automatic int model_lat(input logic [2:0] o, input int mul_lat);
        return (o == 3'd4) ? mul_lat : 1;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    // Compliant initiator: raise start, scramble inputs after E0, drop start
    // once both instances have reported done
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] o);
        logic [15:0] exp_res;
        logic [15:0] r0;
        logic [15:0] r1;
        int k;
        int k0;
        int k1;
        exp_res = model_result(a, b, o);
        r0 = 16'h0; r1 = 16'h0; k = 0; k0 = 0; k1 = 0;
        @(negedge clk);
        A = a; B = b; op = o; start = 1'b1;
        @(posedge clk);
        while ((k < 20) && ((k0 == 0) || (k1 == 0))) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (done && (k0 == 0)) begin k0 = k; r0 = result; end
            if (done1 && (k1 == 0)) begin k1 = k; r1 = result1; end
            A = 8'($urandom);
            B = 8'($urandom);
            op = 3'($urandom_range(0, 6));
        end
        start = 1'b0;
        check_output({tag, "_lat3"}, k0, model_lat(o, 3));
        check_output({tag, "_lat1"}, k1, model_lat(o, 1));
        check_output({tag, "_res3"}, r0, exp_res);
        check_output({tag, "_res1"}, r1, exp_res);
        @(negedge clk);
        check_output({tag, "_donefall"}, done, 1'b0);
        check_output({tag, "_hold"}, result, exp_res);
        last_res = exp_res;
    endtask

    // Global bound in case something wedges
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence followed by randomized operations
    initial begin
        int pulses;
        logic [2:0] ro;
        n_total = 0; n_pass = 0; n_fail = 0; last_res = 16'h0;
        reset = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; op = 3'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output("reset_done", done, 1'b0);
        check_output("reset_result", result, 16'h0000);
        reset = 1'b0;

        run_op("add_ff", 8'hFF, 8'hFF, 3'd1);
        check_output("add_ff_val", result, 16'h01FE);
        run_op("and", 8'hF0, 8'h3C, 3'd2);
        check_output("and_val", result, 16'h0030);
        run_op("xor", 8'hF0, 8'h3C, 3'd3);
        check_output("xor_val", result, 16'h00CC);
        run_op("mul_ff", 8'hFF, 8'hFF, 3'd4);
        check_output("mul_ff_val", result, 16'hFE01);

        // reset held two edges while a multiply is in flight
        @(negedge clk);
        A = 8'h10; B = 8'h10; op = 3'd4; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output("midreset_done", done, 1'b0);
        check_output("midreset_result", result, 16'h0000);
        reset = 1'b0; start = 1'b0;
        count_done(6, pulses);
        check_output("midreset_quiet", pulses, 0);
        check_output("midreset_result2", result, 16'h0000);

        // start held high: one pulse, then one more after a one-cycle drop
        @(negedge clk);
        A = 8'h01; B = 8'h02; op = 3'd1; start = 1'b1;
        count_done(8, pulses);
        check_output("held_pulses", pulses, 1);
        check_output("held_result", result, 16'h0003);
        start = 1'b0;
        @(negedge clk);
        A = 8'h04; B = 8'h05; start = 1'b1;
        count_done(6, pulses);
        check_output("rearm_pulses", pulses, 1);
        check_output("rearm_result", result, 16'h0009);
        start = 1'b0;
        @(negedge clk);
        last_res = 16'h0009;

        // no_op for one cycle leaves everything alone
        @(negedge clk);
        A = 8'($urandom); B = 8'($urandom); op = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        count_done(4, pulses);
        check_output("noop_pulses", pulses, 0);
        check_output("noop_result", result, last_res);

        run_op("op101", 8'($urandom), 8'($urandom), 3'd5);
        check_output("op101_val", result, 16'h0000);

        // rst_op sampled at E1 of a multiply
        run_op("pre_rstop", 8'h21, 8'h03, 3'd1);
        @(negedge clk);
        A = 8'h10; B = 8'h10; op = 3'd4; start = 1'b1;
        @(negedge clk);
        op = 3'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        check_output("rstop_done", done, 1'b0);
        check_output("rstop_done1", done1, 1'b0);
        check_output("rstop_result", result, 16'h0000);
        check_output("rstop_result1", result1, 16'h0000);
        count_done(5, pulses);
        check_output("rstop_quiet", pulses, 0);
        run_op("post_rstop", 8'h05, 8'h06, 3'd1);
        check_output("post_rstop_val", result, 16'h000B);

        // randomized operations against the model
        for (int i = 0; i < 25; i++) begin
            ro = 3'($urandom_range(1, 6));
            run_op("rand", 8'($urandom), 8'($urandom), ro);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tinyalu_resp.md
# tinyalu_resp

Responder end of the TinyALU start/done operation protocol: samples operands and an opcode when the initiator raises `start`, executes add/and/xor in a fixed single-cycle latency and multiply in a configurable multi-cycle latency, then returns `result` with a one-cycle `done` pulse. It is the DUT-side counterpart of the testbench BFM that drives `A`, `B`, `op` and `start`. It sits directly on that interface in the lab testbench top.

## Interface

- `MUL_LAT`, default 3: cycles from capture to `done` for multiply; legal range 1..15.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `A`  in  8  operand A, unsigned.
- `B`  in  8  operand B, unsigned.
- `op`  in  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101/110 unused, 111 rst_op.
- `start`  in  1  operation request, level; the initiator holds it high until it sees `done`.
- `done`  out  1  one-cycle completion pulse; registered.
- `result`  out  16  operation result; registered; holds until the next completion or clear.

## Operation

- States: IDLE, EXEC, DONE, HOLD. Internal 4-bit down-counter `cnt`, plus captured registers `a_q`, `b_q` and `op_q`.
- Reset: `reset`=1 at an edge sets state to IDLE, `done` to 0, `result` to 16'h0000 and `cnt` to 0. Reset has priority over everything else.
- rst_op: `start`=1 with `op`=111 at an edge, in any state, has the same effect as reset. No `done` is produced.
- IDLE:
  - `start`=1 with `op`=000: no state change, no `done`, `result` unchanged.
  - `start`=1 with `op` in {001,010,011,101,110}: capture A/B/op, set `cnt`=0, go to EXEC.
  - `start`=1 with `op`=100: capture A/B/op, set `cnt`=MUL_LAT-1, go to EXEC.
- EXEC:
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`=0: write `result`, set `done`=1 and go to DONE.
  - `start`, `A`, `B` and `op` are ignored, except for rst_op.
- DONE: clear `done`. Go to HOLD if `start`=1, otherwise go to IDLE.
- HOLD: go to IDLE on the first edge that samples `start`=0. This re-arm rule guarantees exactly one operation per `start` assertion.
- Arithmetic, all unsigned and computed from the captured operands:
  - add: {7'b0, a_q + b_q}, 9-bit sum.
  - and: {8'b0, a_q & b_q}.
  - xor: {8'b0, a_q ^ b_q}.
  - mul: a_q * b_q, full 16-bit product.
  - 101/110: 16'h0000, still completing with `done`.

## Timing

- E0 is the edge that samples `start`=1 in IDLE.
- Single-cycle ops: `result` and `done` are valid after E1. `done` falls after E2.
- mul: `result` and `done` are valid after E_MUL_LAT. `done` falls after E_(MUL_LAT+1).
- Operand or opcode changes after E0 do not affect the operation in flight.
- If `start` drops during EXEC, the operation still completes and pulses `done`.
- With a compliant initiator (`start` dropped on the negedge after `done`), DONE goes straight to IDLE. The next op can be sampled two edges after `done` rises.
- If `start` stays high through DONE, the block enters HOLD and accepts no new op until `start` has been low for at least one edge.
- `result` never changes except on a completion edge, reset or rst_op.

## Test plan

- Reset held for 2 edges mid-activity -> `done`=0, `result`=16'h0000; no `done` afterwards while `start`=0.
- add A=8'hFF, B=8'hFF -> `done` high exactly one cycle after E1, `result`=16'h01FE; and 8'hF0/8'h3C -> 16'h0030; xor 8'hF0/8'h3C -> 16'h00CC.
- mul A=8'hFF, B=8'hFF with MUL_LAT=3; A and B driven to 0 after E1 -> `done` after E3 only, `result`=16'hFE01. Repeat with MUL_LAT=1 -> `done` after E1.
- `start` held high continuously with add 8'h01/8'h02 -> exactly one `done` pulse, `result`=16'h0003. Drop `start` for one cycle and raise it again -> exactly one more pulse.
- no_op with `start` for one cycle after a completed op -> no `done`, `result` unchanged. Opcode 101 -> `done` after E1 with `result`=16'h0000.
- mul 8'h10 × 8'h10 with rst_op (or `reset`) applied at E1 -> no `done`, `result`=16'h0000, state IDLE. A following add 8'h05/8'h06 -> 16'h000B after E1.
